manta_bus_arbiter: RTL and testbench

//  Shares the single Manta core bus (addr/data/rw/valid chain through the cores) between NUM_REQ hosts,
//  e.g. the UART bridge_rx and an on-chip autopoll sequencer. Buffers one request per host and

---
 rtl/manta_bus_pkg.sv | 25 ++
 rtl/manta_bus_rr_pick.sv | 36 +++
 rtl/manta_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_manta_bus_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/manta_bus_pkg.sv
// Shared types and defaults for the Manta core-bus arbiter.
// Holds the bus width defaults, the request record, the arbiter state encoding and a wrap helper.
package manta_bus_pkg;

   localparam int MANTA_ADDR_W = 16;
   localparam int MANTA_DATA_W = 16;

   typedef struct packed {
      logic [MANTA_ADDR_W-1:0] addr;
      logic [MANTA_DATA_W-1:0] data;
      logic                    rw;
   } bus_req_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } arb_state_t;

   // Next round-robin position after v among n hosts.
   function automatic int wrap_inc(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/manta_bus_rr_pick.sv
// Combinational round-robin picker: first pending host at or after ptr, wrapping.
// Produces a one-hot grant and a flag telling whether anything is pending at all.
module rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] pending,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic               any
);

   // Walk offsets from the pointer; the inner loop keeps all selects constant after unrolling.
   always_comb begin
      int   target;
      logic found;
      grant  = '0;
      target = 0;
      found  = 1'b0;
      for (int o = 0; o < NUM_REQ; o++) begin
         target = int'(ptr) + o;
         if (target >= NUM_REQ) begin
            target = target - NUM_REQ;
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && (i == target) && pending[i]) begin
               grant[i] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

   assign any = |pending;

endmodule

// File: rtl/manta_bus_arbiter.sv
// Shares the Manta core chain between NUM_REQ hosts: one buffered request per host,
// round-robin issue, one transaction in flight, response routed back or timed out.
module manta_bus_arbiter
   import manta_bus_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = MANTA_ADDR_W,
   parameter int DATA_W  = MANTA_DATA_W,
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]        req_rw_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [DATA_W-1:0]         rsp_data_o,
   output logic                      rsp_err_o,
   output logic [NUM_REQ-1:0]        rsp_valid_o,
   output logic [NUM_REQ-1:0]        overflow_o,
   output logic [ADDR_W-1:0]         bus_addr_o,
   output logic [DATA_W-1:0]         bus_data_o,
   output logic                      bus_rw_o,
   output logic                      bus_valid_o,
   input  logic [DATA_W-1:0]         ret_data_i,
   input  logic                      ret_rw_i,
   input  logic                      ret_valid_i
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   arb_state_t          state;
   logic [NUM_REQ-1:0]  pending;
   logic [NUM_REQ-1:0]  retire;
   logic [NUM_REQ-1:0]  pick_grant;
   logic                pick_any;
   logic [PTR_W-1:0]    pick_idx;
   logic [PTR_W-1:0]    rr_ptr;
   logic [NUM_REQ-1:0]  grant_oh_q;
   logic [PTR_W-1:0]    grant_idx_q;
   logic [CNT_W-1:0]    tmo_cnt;

   logic [ADDR_W-1:0]   hold_addr [NUM_REQ];
   logic [DATA_W-1:0]   hold_data [NUM_REQ];
   logic                hold_rw   [NUM_REQ];

   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_data;
   logic                sel_rw;

   // The return rw flag travels with the chain for debug visibility only.
   logic                unused_ret_rw;
   assign unused_ret_rw = ret_rw_i;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_pick (
      .pending (pending),
      .ptr     (rr_ptr),
      .grant   (pick_grant),
      .any     (pick_any)
   );

   assign retire = (state == RESP) ? grant_oh_q : '0;

   // Steer the granted holding register to the bus and encode its index for the pointer update.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      sel_rw   = 1'b0;
      pick_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (pick_grant[k]) begin
            sel_addr = hold_addr[k];
            sel_data = hold_data[k];
            sel_rw   = hold_rw[k];
            pick_idx = PTR_W'(k);
         end
      end
   end

   // A slot being retired this cycle can take a new request without counting as an overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending    <= '0;
         overflow_o <= '0;
         for (int k = 0; k < NUM_REQ; k++) begin
            hold_addr[k] <= '0;
            hold_data[k] <= '0;
            hold_rw[k]   <= 1'b0;
         end
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (req_valid_i[k] && (!pending[k] || retire[k])) begin
               hold_addr[k] <= req_addr_i[k*ADDR_W +: ADDR_W];
               hold_data[k] <= req_data_i[k*DATA_W +: DATA_W];
               hold_rw[k]   <= req_rw_i[k];
               pending[k]   <= 1'b1;
            end else if (req_valid_i[k]) begin
               overflow_o[k] <= 1'b1;
            end else if (retire[k]) begin
               pending[k] <= 1'b0;
            end
         end
      end
   end

   // Bus and response outputs are pulses: cleared every cycle unless the FSM sets them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         grant_oh_q  <= '0;
         grant_idx_q <= '0;
         tmo_cnt     <= '0;
         bus_addr_o  <= '0;
         bus_data_o  <= '0;
         bus_rw_o    <= 1'b0;
         bus_valid_o <= 1'b0;
         rsp_data_o  <= '0;
         rsp_err_o   <= 1'b0;
         rsp_valid_o <= '0;
      end else begin
         bus_addr_o  <= '0;
         bus_data_o  <= '0;
         bus_rw_o    <= 1'b0;
         bus_valid_o <= 1'b0;
         rsp_data_o  <= '0;
         rsp_err_o   <= 1'b0;
         rsp_valid_o <= '0;
         unique case (state)
            IDLE: begin
               if (pick_any) begin
                  grant_oh_q  <= pick_grant;
                  grant_idx_q <= pick_idx;
                  bus_addr_o  <= sel_addr;
                  bus_data_o  <= sel_data;
                  bus_rw_o    <= sel_rw;
                  bus_valid_o <= 1'b1;
                  tmo_cnt     <= CNT_W'(TIMEOUT);
                  state       <= WAIT;
               end
            end
            WAIT: begin
               if (ret_valid_i) begin
                  rsp_data_o  <= ret_data_i;
                  rsp_err_o   <= 1'b0;
                  rsp_valid_o <= grant_oh_q;
                  state       <= RESP;
               end else if (tmo_cnt == '0) begin
                  rsp_data_o  <= '0;
                  rsp_err_o   <= 1'b1;
                  rsp_valid_o <= grant_oh_q;
                  state       <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt - 1'b1;
               end
            end
            RESP: begin
               rr_ptr <= PTR_W'(wrap_inc(int'(grant_idx_q), NUM_REQ));
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_manta_bus_arbiter.sv
// Directed bench for manta_bus_arbiter with a small core-chain model.
// The chain echoes write data, or returns addr ^ 0x00A4 for reads, after chain_lat cycles.
module tb_manta_bus_arbiter;
   import manta_bus_pkg::*;

   localparam int NUM_REQ = 2;
   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 16;
   localparam int TIMEOUT = 4;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b1;
   logic [NUM_REQ*ADDR_W-1:0] req_addr_i = '0;
   logic [NUM_REQ*DATA_W-1:0] req_data_i = '0;
   logic [NUM_REQ-1:0]        req_rw_i = '0;
   logic [NUM_REQ-1:0]        req_valid_i = '0;
   logic [DATA_W-1:0]         rsp_data_o;
   logic                      rsp_err_o;
   logic [NUM_REQ-1:0]        rsp_valid_o;
   logic [NUM_REQ-1:0]        overflow_o;
   logic [ADDR_W-1:0]         bus_addr_o;
   logic [DATA_W-1:0]         bus_data_o;
   logic                      bus_rw_o;
   logic                      bus_valid_o;
   logic [DATA_W-1:0]         ret_data_i = '0;
   logic                      ret_rw_i = 1'b0;
   logic                      ret_valid_i = 1'b0;

   int checks = 0;
   int errors = 0;
   int chain_lat = 0;
   bit late_ret = 1'b0;
   int cyc = 0;

   logic [ADDR_W-1:0]  iss_addr [64];
   logic [DATA_W-1:0]  iss_data [64];
   logic               iss_rw   [64];
   int                 iss_cyc  [64];
   int                 iss_cnt = 0;
   logic [NUM_REQ-1:0] rsp_vec  [64];
   logic [DATA_W-1:0]  rsp_dat  [64];
   logic               rsp_er   [64];
   int                 rsp_cyc  [64];
   int                 rsp_cnt = 0;
   bit                 prev_bus_valid = 1'b0;
   int                 b2b = 0;

   manta_bus_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_addr_i  (req_addr_i),
      .req_data_i  (req_data_i),
      .req_rw_i    (req_rw_i),
      .req_valid_i (req_valid_i),
      .rsp_data_o  (rsp_data_o),
      .rsp_err_o   (rsp_err_o),
      .rsp_valid_o (rsp_valid_o),
      .overflow_o  (overflow_o),
      .bus_addr_o  (bus_addr_o),
      .bus_data_o  (bus_data_o),
      .bus_rw_o    (bus_rw_o),
      .bus_valid_o (bus_valid_o),
      .ret_data_i  (ret_data_i),
      .ret_rw_i    (ret_rw_i),
      .ret_valid_i (ret_valid_i)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log every bus pulse and response pulse with the cycle it appeared in.
   always @(negedge clk) begin
      if (bus_valid_o) begin
         if (prev_bus_valid) b2b++;
         if (iss_cnt < 64) begin
            iss_addr[iss_cnt] = bus_addr_o;
            iss_data[iss_cnt] = bus_data_o;
            iss_rw[iss_cnt]   = bus_rw_o;
            iss_cyc[iss_cnt]  = cyc;
         end
         iss_cnt++;
      end
      prev_bus_valid = bus_valid_o;
      if (rsp_valid_o != '0) begin
         if (rsp_cnt < 64) begin
            rsp_vec[rsp_cnt] = rsp_valid_o;
            rsp_dat[rsp_cnt] = rsp_data_o;
            rsp_er[rsp_cnt]  = rsp_err_o;
            rsp_cyc[rsp_cnt] = cyc;
         end
         rsp_cnt++;
      end
   end

   // Core chain: latency chain_lat (0 means it never answers); late_ret forces a stray return.
   initial begin : chain_model
      int                remain;
      logic [ADDR_W-1:0] s_addr;
      logic [DATA_W-1:0] s_data;
      logic              s_rw;
      remain = 0;
      s_addr = '0;
      s_data = '0;
      s_rw   = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         ret_valid_i = 1'b0;
         ret_data_i  = '0;
         ret_rw_i    = 1'b0;
         if (remain > 0) begin
            remain--;
            if (remain == 0) begin
               ret_valid_i = 1'b1;
               ret_data_i  = s_rw ? s_data : (s_addr ^ 16'h00A4);
               ret_rw_i    = s_rw;
            end
         end
         if (bus_valid_o && chain_lat > 0) begin
            s_addr = bus_addr_o;
            s_data = bus_data_o;
            s_rw   = bus_rw_o;
            if (chain_lat == 1) begin
               ret_valid_i = 1'b1;
               ret_data_i  = s_rw ? s_data : (s_addr ^ 16'h00A4);
               ret_rw_i    = s_rw;
            end else begin
               remain = chain_lat - 1;
            end
         end
         if (late_ret) begin
            ret_valid_i = 1'b1;
            ret_data_i  = 16'hDEAD;
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   task automatic waitNeg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive one cycle of request pulses from the current negedge; returns at the next negedge.
   task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] rw,
                                input logic [15:0] a0, input logic [15:0] d0,
                                input logic [15:0] a1, input logic [15:0] d1);
      req_addr_i  = {a1, a0};
      req_data_i  = {d1, d0};
      req_rw_i    = rw;
      req_valid_i = valid;
      @(negedge clk);
      req_valid_i = '0;
   endtask

   initial begin : stimulus
      int n;
      int r;
      int c0;

      #1 rst_n = 1'b0;
      waitNeg(2);
      checkOutput("reset_bus_valid", 32'(bus_valid_o), 32'd0);
      checkOutput("reset_bus_addr", 32'(bus_addr_o), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("reset_rsp_err", 32'(rsp_err_o), 32'd0);
      checkOutput("reset_overflow", 32'(overflow_o), 32'd0);
      rst_n = 1'b1;
      waitNeg(2);

      $display("[TB] single read from host0");
      chain_lat = 2;
      n  = iss_cnt;
      r  = rsp_cnt;
      c0 = cyc;
      applyStimulus(2'b01, 2'b00, 16'h0001, 16'h0000, 16'h0000, 16'h0000);
      waitNeg(10);
      checkOutput("t1_issue_count", 32'(iss_cnt - n), 32'd1);
      checkOutput("t1_issue_addr", 32'(iss_addr[n]), 32'h0001);
      checkOutput("t1_issue_rw", 32'(iss_rw[n]), 32'd0);
      checkOutput("t1_issue_latency", 32'(iss_cyc[n] - c0), 32'd2);
      checkOutput("t1_rsp_count", 32'(rsp_cnt - r), 32'd1);
      checkOutput("t1_rsp_vec", 32'(rsp_vec[r]), 32'h1);
      checkOutput("t1_rsp_data", 32'(rsp_dat[r]), 32'h00A5);
      checkOutput("t1_rsp_err", 32'(rsp_er[r]), 32'd0);
      checkOutput("t1_rsp_delay", 32'(rsp_cyc[r] - iss_cyc[n]), 32'd2);

      $display("[TB] round robin between host0 and host1");
      n = iss_cnt;
      r = rsp_cnt;
      applyStimulus(2'b11, 2'b00, 16'h0010, 16'h0000, 16'h0020, 16'h0000);
      waitNeg(14);
      applyStimulus(2'b10, 2'b00, 16'h0000, 16'h0000, 16'h0021, 16'h0000);
      waitNeg(8);
      applyStimulus(2'b11, 2'b00, 16'h0012, 16'h0000, 16'h0022, 16'h0000);
      waitNeg(14);
      checkOutput("t2_issue_count", 32'(iss_cnt - n), 32'd5);
      checkOutput("t2_first_addr", 32'(iss_addr[n]), 32'h0020);
      checkOutput("t2_second_addr", 32'(iss_addr[n+1]), 32'h0010);
      checkOutput("t2_issue_gap", 32'(iss_cyc[n+1] - iss_cyc[n]), 32'd4);
      checkOutput("t2_third_addr", 32'(iss_addr[n+2]), 32'h0021);
      checkOutput("t2_fourth_addr", 32'(iss_addr[n+3]), 32'h0012);
      checkOutput("t2_fifth_addr", 32'(iss_addr[n+4]), 32'h0022);
      checkOutput("t2_rsp0_vec", 32'(rsp_vec[r]), 32'h2);
      checkOutput("t2_rsp0_data", 32'(rsp_dat[r]), 32'h0084);
      checkOutput("t2_rsp1_vec", 32'(rsp_vec[r+1]), 32'h1);
      checkOutput("t2_rsp1_data", 32'(rsp_dat[r+1]), 32'h00B4);
      checkOutput("t2_overflow", 32'(overflow_o), 32'd0);

      $display("[TB] host1 second request during WAIT is dropped");
      chain_lat = 4;
      n = iss_cnt;
      r = rsp_cnt;
      applyStimulus(2'b10, 2'b10, 16'h0000, 16'h0000, 16'h0030, 16'h1234);
      waitNeg(1);
      applyStimulus(2'b10, 2'b10, 16'h0000, 16'h0000, 16'h0031, 16'h5678);
      checkOutput("t3_overflow_now", 32'(overflow_o), 32'h2);
      waitNeg(10);
      checkOutput("t3_issue_count", 32'(iss_cnt - n), 32'd1);
      checkOutput("t3_issue_data", 32'(iss_data[n]), 32'h1234);
      checkOutput("t3_issue_rw", 32'(iss_rw[n]), 32'd1);
      checkOutput("t3_rsp_count", 32'(rsp_cnt - r), 32'd1);
      checkOutput("t3_rsp_vec", 32'(rsp_vec[r]), 32'h2);
      checkOutput("t3_rsp_data", 32'(rsp_dat[r]), 32'h1234);
      checkOutput("t3_overflow_sticky", 32'(overflow_o), 32'h2);

      $display("[TB] timeout with no chain return");
      chain_lat = 0;
      n = iss_cnt;
      r = rsp_cnt;
      applyStimulus(2'b01, 2'b00, 16'h0040, 16'h0000, 16'h0000, 16'h0000);
      waitNeg(10);
      checkOutput("t4_rsp_count", 32'(rsp_cnt - r), 32'd1);
      checkOutput("t4_rsp_vec", 32'(rsp_vec[r]), 32'h1);
      checkOutput("t4_rsp_err", 32'(rsp_er[r]), 32'd1);
      checkOutput("t4_rsp_data", 32'(rsp_dat[r]), 32'd0);
      checkOutput("t4_rsp_delay", 32'(rsp_cyc[r] - iss_cyc[n]), 32'd5);
      late_ret = 1'b1;
      waitNeg(1);
      late_ret = 1'b0;
      waitNeg(4);
      checkOutput("t4_late_ignored", 32'(rsp_cnt - r), 32'd1);
      checkOutput("t4_err_cleared", 32'(rsp_err_o), 32'd0);

      $display("[TB] host0 request on its own response cycle");
      chain_lat = 2;
      n = iss_cnt;
      r = rsp_cnt;
      applyStimulus(2'b01, 2'b00, 16'h0050, 16'h0000, 16'h0000, 16'h0000);
      waitNeg(3);
      checkOutput("t5_rsp_live", 32'(rsp_valid_o), 32'h1);
      applyStimulus(2'b01, 2'b00, 16'h0051, 16'h0000, 16'h0000, 16'h0000);
      waitNeg(10);
      checkOutput("t5_issue_count", 32'(iss_cnt - n), 32'd2);
      checkOutput("t5_second_addr", 32'(iss_addr[n+1]), 32'h0051);
      checkOutput("t5_issue_gap", 32'(iss_cyc[n+1] - iss_cyc[n]), 32'd4);
      checkOutput("t5_rsp0_data", 32'(rsp_dat[r]), 32'h00F4);
      checkOutput("t5_rsp1_data", 32'(rsp_dat[r+1]), 32'h00F5);
      checkOutput("t5_overflow", 32'(overflow_o), 32'h2);

      $display("[TB] reset during WAIT");
      chain_lat = 0;
      applyStimulus(2'b10, 2'b00, 16'h0000, 16'h0000, 16'h0060, 16'h0000);
      waitNeg(2);
      rst_n = 1'b0;
      #1;
      checkOutput("t6_bus_valid", 32'(bus_valid_o), 32'd0);
      checkOutput("t6_rsp_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("t6_overflow", 32'(overflow_o), 32'd0);
      r = rsp_cnt;
      waitNeg(2);
      rst_n = 1'b1;
      waitNeg(10);
      checkOutput("t6_no_rsp_after", 32'(rsp_cnt - r), 32'd0);
      chain_lat = 2;
      n = iss_cnt;
      r = rsp_cnt;
      applyStimulus(2'b11, 2'b00, 16'h0070, 16'h0000, 16'h0071, 16'h0000);
      waitNeg(14);
      checkOutput("t6_issue_count", 32'(iss_cnt - n), 32'd2);
      checkOutput("t6_first_addr", 32'(iss_addr[n]), 32'h0070);
      checkOutput("t6_second_addr", 32'(iss_addr[n+1]), 32'h0071);
      checkOutput("t6_rsp0_data", 32'(rsp_dat[r]), 32'h00D4);
      checkOutput("t6_rsp1_vec", 32'(rsp_vec[r+1]), 32'h2);
      checkOutput("t6_rsp1_data", 32'(rsp_dat[r+1]), 32'h00D5);

      checkOutput("no_back_to_back", 32'(b2b), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
